// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller: register map,
// reset values, the CTRL register layout and the hex-to-segment decoder.
package sevenseg_pkg;

    localparam logic [2:0] ADR_DIGITS = 3'd0;
    localparam logic [2:0] ADR_ENABLE = 3'd1;
    localparam logic [2:0] ADR_CTRL   = 3'd2;
    localparam logic [2:0] ADR_DPMASK = 3'd3;
    localparam logic [2:0] ADR_RAW_LO = 3'd4;
    localparam logic [2:0] ADR_RAW_HI = 3'd5;

    localparam logic [31:0] DIGITS_RST = 32'h0000_0000;
    localparam logic [7:0]  ENABLE_RST = 8'hFF;
    localparam logic [7:0]  DPMASK_RST = 8'h00;
    localparam logic [31:0] RAW_RST    = 32'h7F7F_7F7F;
    // Bit 7 of each raw byte has no segment behind it and reads back 0.
    localparam logic [31:0] RAW_MASK   = 32'h7F7F_7F7F;

    typedef struct packed {
        logic       raw_mode;
        logic [3:0] brightness;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{raw_mode: 1'b0, brightness: 4'hF};

    // Active-low segment pattern, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hexdecode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_wb_regs.sv
// Wishbone slave and register file for the seven-segment controller.
// Every request is acked one cycle after it is seen, never on two
// consecutive cycles. Define SEVENSEG_RAW_EN to add the raw-segment
// registers (RAW_LO/RAW_HI) and the CTRL raw-mode bit.
module sevenseg_wb_regs
    import sevenseg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  wb_adr,
    input  logic [31:0] wb_dat,
    input  logic [3:0]  wb_sel,
    input  logic        wb_we,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    output logic [31:0] wb_rdt,
    output logic        wb_ack,
    output logic [31:0] digits,
    output logic [7:0]  enable,
    output logic [7:0]  dpmask,
    output logic [3:0]  brightness,
    output logic        raw_mode,
    output logic [55:0] raw_seg
);

    ctrl_t       ctrl_q;
    logic        req;
    logic        wr;
    logic [31:0] wmask;
    logic [31:0] rd_data;
    logic [31:0] wr_val;
`ifdef SEVENSEG_RAW_EN
    logic [31:0] raw_lo_q;
    logic [31:0] raw_hi_q;
`endif

    assign req        = wb_cyc & wb_stb & ~wb_ack;
    assign wr         = req & wb_we;
    assign wmask      = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
    assign brightness = ctrl_q.brightness;
    assign raw_mode   = ctrl_q.raw_mode;

    // Read view of the addressed register; also the base for byte-masked writes.
    always_comb begin
        rd_data = '0;
        case (wb_adr)
            ADR_DIGITS: rd_data = digits;
            ADR_ENABLE: rd_data = {24'h0, enable};
            ADR_CTRL:   rd_data = {23'h0, ctrl_q.raw_mode, 4'h0, ctrl_q.brightness};
            ADR_DPMASK: rd_data = {24'h0, dpmask};
`ifdef SEVENSEG_RAW_EN
            ADR_RAW_LO: rd_data = raw_lo_q;
            ADR_RAW_HI: rd_data = raw_hi_q;
`endif
            default:    rd_data = '0;
        endcase
        wr_val = (rd_data & ~wmask) | (wb_dat & wmask);
    end

`ifdef SEVENSEG_RAW_EN
    // Pack the 7 live bits of each raw byte, digit 0 in the low bits.
    always_comb begin
        raw_seg = '1;
        for (int k = 0; k < 4; k++) begin
            raw_seg[7*k +: 7]     = raw_lo_q[8*k +: 7];
            raw_seg[7*(k+4) +: 7] = raw_hi_q[8*k +: 7];
        end
    end
`else
    assign raw_seg = {8{7'h7F}};
`endif

    // Ack/read-data generation and register commits on the ack edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack <= 1'b0;
            wb_rdt <= '0;
            digits <= DIGITS_RST;
            enable <= ENABLE_RST;
            dpmask <= DPMASK_RST;
            ctrl_q <= CTRL_RST;
`ifdef SEVENSEG_RAW_EN
            raw_lo_q <= RAW_RST;
            raw_hi_q <= RAW_RST;
`endif
        end else begin
            wb_ack <= req;
            wb_rdt <= req ? rd_data : '0;
            if (wr) begin
                case (wb_adr)
                    ADR_DIGITS: digits <= wr_val;
                    ADR_ENABLE: enable <= wr_val[7:0];
                    ADR_CTRL: begin
                        ctrl_q.brightness <= wr_val[3:0];
`ifdef SEVENSEG_RAW_EN
                        ctrl_q.raw_mode   <= wr_val[8];
`endif
                    end
                    ADR_DPMASK: dpmask <= wr_val[7:0];
`ifdef SEVENSEG_RAW_EN
                    ADR_RAW_LO: raw_lo_q <= wr_val & RAW_MASK;
                    ADR_RAW_HI: raw_hi_q <= wr_val & RAW_MASK;
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment driver: time-slices the digits onto
// shared segment lines with 16-step brightness PWM inside each dwell.
// All pin outputs are registered and active-low. SEVENSEG_RAW_EN enables
// raw segment mode (see sevenseg_wb_regs).
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV = 6250
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic [7:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_dp
);

    localparam int DIV_W = $clog2(REFRESH_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(REFRESH_DIV - 1);

    logic [31:0]      digits;
    logic [7:0]       enable;
    logic [7:0]       dpmask;
    logic [3:0]       brightness;
    logic             raw_mode;
    logic [55:0]      raw_seg;

    logic [DIV_W-1:0] presc;
    logic [3:0]       pwm_cnt;
    logic [2:0]       digit_idx;
    logic             tick;
    logic [5:0]       raw_base;
    logic [7:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    sevenseg_wb_regs u_regs (
        .clk        (clk),
        .rst        (rst),
        .wb_adr     (i_wb_adr),
        .wb_dat     (i_wb_dat),
        .wb_sel     (i_wb_sel),
        .wb_we      (i_wb_we),
        .wb_cyc     (i_wb_cyc),
        .wb_stb     (i_wb_stb),
        .wb_rdt     (o_wb_rdt),
        .wb_ack     (o_wb_ack),
        .digits     (digits),
        .enable     (enable),
        .dpmask     (dpmask),
        .brightness (brightness),
        .raw_mode   (raw_mode),
        .raw_seg    (raw_seg)
    );

    assign tick     = (presc == DIV_TC);
    assign raw_base = 6'(digit_idx) * 6'd7;

    // Prescaler -> PWM step -> digit index cascade.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            digit_idx <= '0;
        end else if (tick) begin
            presc   <= '0;
            pwm_cnt <= pwm_cnt + 4'd1;
            if (pwm_cnt == 4'hF) begin
                digit_idx <= digit_idx + 3'd1;
            end
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Pin values for the current slot; segments stay driven through the PWM off-time.
    always_comb begin
        an_next = '1;
        if (pwm_cnt <= brightness) begin
            an_next[digit_idx] = ~enable[digit_idx];
        end
        seg_next = raw_mode ? raw_seg[raw_base +: 7]
                            : hexdecode(digits[{digit_idx, 2'b00} +: 4]);
        dp_next  = ~dpmask[digit_idx];
    end

    // Registered pin stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_an  <= 8'hFF;
            o_seg <= 7'h7F;
            o_dp  <= 1'b1;
        end else begin
            o_an  <= an_next;
            o_seg <= seg_next;
            o_dp  <= dp_next;
        end
    end

endmodule
